// File: rtl/ps2_scan_receiver_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
`timescale 1ns/1ps
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_event_t;

    // PS/2 uses odd parity: data bits plus parity bit must carry an odd number of ones.
    function automatic logic odd_weight(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// Key-event handshake between the receiver (master) and its consumer (slave).
`timescale 1ns/1ps
interface ps2_scan_receiver_if #(
    parameter int FIFO_DEPTH = 8
) ();

    logic                              Event_Valid;
    logic                              Event_Ready;
    logic [7:0]                        Event_Code;
    logic                              Event_Ext;
    logic                              Event_Break;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   Event_Count;

    modport master (
        output Event_Valid,
        output Event_Code,
        output Event_Ext,
        output Event_Break,
        output Event_Count,
        input  Event_Ready
    );

    modport slave (
        input  Event_Valid,
        input  Event_Code,
        input  Event_Ext,
        input  Event_Break,
        input  Event_Count,
        output Event_Ready
    );

endinterface

// File: rtl/ps2_scan_receiver_fifo.sv
// First-word fall-through FIFO of decoded key events.
`timescale 1ns/1ps
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  ps2_event_t                     push_data,
    input  logic                           pop,
    output ps2_event_t                     pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    ps2_event_t    mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == COUNT_FULL);
    assign count    = count_reg;
    assign do_pop   = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// System-clocked PS/2 keyboard receiver: synchronise, glitch-filter, frame-check,
// fold E0/F0 prefixes and queue key events for the consumer.
`timescale 1ns/1ps
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    PS2_Clk,
    input  logic                    PS2_Data,
    ps2_scan_receiver_if.master     evt,
    output logic                    Frame_Err,
    output logic                    Overflow
);

    localparam int FW = $clog2(FILTER_LEN+1);
    localparam int TW = $clog2(TIMEOUT_CYC+1);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN-1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC-1);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_s;
    logic                   data_s;

    logic                   filt_clk_reg;
    logic [FW-1:0]          filt_cnt_reg;
    logic                   filt_flip;
    logic                   fall_edge;

    rx_state_t              state_reg, state_next;
    logic [2:0]             bit_idx_reg, bit_idx_next;
    logic [7:0]             shift_reg, shift_next;
    logic                   parity_reg, parity_next;
    logic                   byte_ok;
    logic                   byte_bad;
    logic                   timeout_hit;
    logic [TW-1:0]          to_cnt_reg;

    logic [7:0]             byte_reg;
    logic                   byte_valid_reg;
    logic                   frame_err_reg;
    logic                   ext_flag_reg;
    logic                   brk_flag_reg;
    logic                   overflow_reg;

    logic                   emit;
    ps2_event_t             emit_event;
    ps2_event_t             head;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;

    assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
    assign data_s = data_sync_reg[SYNC_STAGES-1];

    // Input synchronisers; both lines idle high so they reset to 1.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], PS2_Clk};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], PS2_Data};
        end
    end

    // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    assign filt_flip = (clk_s != filt_clk_reg) && (filt_cnt_reg == FILT_LAST);
    assign fall_edge = filt_flip & filt_clk_reg;

    // Glitch filter on the synchronised keyboard clock.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            filt_clk_reg <= 1'b1;
            filt_cnt_reg <= '0;
        end else if (clk_s == filt_clk_reg) begin
            filt_cnt_reg <= '0;
        end else if (filt_flip) begin
            filt_clk_reg <= clk_s;
            filt_cnt_reg <= '0;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
    end

    // Stall watchdog: runs only inside a frame and restarts on every edge.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            to_cnt_reg <= '0;
        end else if (state_reg == IDLE || fall_edge) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg   <= IDLE;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            parity_reg  <= parity_next;
        end
    end

    // Frame FSM next state: one step per edge; an edge beats a same-cycle timeout.
    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        byte_ok      = 1'b0;
        byte_bad     = 1'b0;
        timeout_hit  = 1'b0;
        if (fall_edge) begin
            case (state_reg)
                IDLE: begin
                    if (!data_s) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
                DATA: begin
                    shift_next = {data_s, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = PARITY;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
                PARITY: begin
                    parity_next = data_s;
                    state_next  = STOP;
                end
                STOP: begin
                    if (data_s && odd_weight({shift_reg, parity_reg})) begin
                        byte_ok = 1'b1;
                    end else begin
                        byte_bad = 1'b1;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE && to_cnt_reg == TO_LAST) begin
            timeout_hit = 1'b1;
            state_next  = IDLE;
        end
    end

    // Register the accepted byte and the error pulse one cycle after the stop edge.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            byte_reg       <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            if (byte_ok) begin
                byte_reg <= shift_reg;
            end
            byte_valid_reg <= byte_ok;
            frame_err_reg  <= byte_bad | timeout_hit;
        end
    end

    // Prefix bytes only arm flags; any other byte becomes an event.
    always_comb begin
        emit       = 1'b0;
        emit_event = '0;
        if (byte_valid_reg && byte_reg != PS2_PREFIX_EXT && byte_reg != PS2_PREFIX_BRK) begin
            emit            = 1'b1;
            emit_event.code = byte_reg;
            emit_event.ext  = ext_flag_reg;
            emit_event.brk  = brk_flag_reg;
        end
    end

    // Prefix flags: set by E0/F0, consumed by the next event, dropped on a bad frame.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ext_flag_reg <= 1'b0;
            brk_flag_reg <= 1'b0;
        end else if (frame_err_reg) begin
            ext_flag_reg <= 1'b0;
            brk_flag_reg <= 1'b0;
        end else if (byte_valid_reg) begin
            if (byte_reg == PS2_PREFIX_EXT) begin
                ext_flag_reg <= 1'b1;
            end else if (byte_reg == PS2_PREFIX_BRK) begin
                brk_flag_reg <= 1'b1;
            end else begin
                ext_flag_reg <= 1'b0;
                brk_flag_reg <= 1'b0;
            end
        end
    end

    assign pop = ~fifo_empty & evt.Event_Ready;

    // Overflow only when the FIFO stays full, i.e. no pop frees a slot this cycle.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= emit & fifo_full & ~pop;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .push      (emit),
        .push_data (emit_event),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign evt.Event_Valid = ~fifo_empty;
    assign evt.Event_Code  = head.code;
    assign evt.Event_Ext   = head.ext;
    assign evt.Event_Break = head.brk;
    assign evt.Event_Count = fifo_count;
    assign Frame_Err       = frame_err_reg;
    assign Overflow        = overflow_reg;

endmodule
